// File: rtl/ray_marcher.sv
`default_nettype none
// ============================================================================
// Module   : ray_marcher
// Purpose  : Producer side of the intersection interface. The block accepts
//            one ray direction per valid/ready handshake. It marches from a
//            fixed origin in fixed steps until one of these happens: the point
//            falls inside a sphere, the step budget runs out, or the next
//            point would leave the signed 12-bit space. It then presents the
//            final point and a hit flag on a valid/ready output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                    in   system clock
//   rst_n                  in   asynchronous active-low reset
//   in_valid / in_ready    in/out  ray handshake (in_ready = idle)
//   dir[2:0][11:0]         in   signed step vector, [0]=x [1]=y [2]=z
//   out_valid / out_ready  out/in  result handshake
//   intersection_location  out  final march point, same indexing as dir
//   is_intersecting        out  1 = point inside sphere, 0 = miss
//   steps_taken            out  (only with RAY_MARCH_STATS_EN) decision step+1
// Optional feature macro: RAY_MARCH_STATS_EN
// ============================================================================
module ray_marcher #(
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0,
    parameter int ORIGIN_Z  = 0,
    parameter int SPHERE_X  = 0,
    parameter int SPHERE_Y  = 0,
    parameter int SPHERE_Z  = 100,
    parameter int RADIUS    = 20,
    parameter int MAX_STEPS = 64,
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0][11:0]  dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0][11:0]  intersection_location,
    output logic              is_intersecting
`ifdef RAY_MARCH_STATS_EN
    ,
    output logic [STEP_W-1:0] steps_taken
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [27:0]       C_RADIUS_SQ = 28'(RADIUS * RADIUS);
    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(MAX_STEPS - 1);

    logic [2:0][11:0] c_origin;
    logic [2:0][11:0] c_centre;
    assign c_origin = {12'(ORIGIN_Z), 12'(ORIGIN_Y), 12'(ORIGIN_X)};
    assign c_centre = {12'(SPHERE_Z), 12'(SPHERE_Y), 12'(SPHERE_X)};

    state_t              state_q, state_d;
    logic [2:0][11:0]    dir_q, dir_d;
    logic [2:0][11:0]    pos_q, pos_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [2:0][11:0]    loc_q, loc_d;
    logic                hit_q, hit_d;
    logic                out_valid_q, out_valid_d;
`ifdef RAY_MARCH_STATS_EN
    logic [STEP_W-1:0]   stats_q, stats_d;
`endif

    // Per-axis distance terms and next-point overflow detection.
    logic [2:0][12:0]    w_diff;
    logic signed [25:0]  w_dx [3];
    logic [2:0][25:0]    w_sq;
    logic [2:0][12:0]    w_sum;
    logic [27:0]         w_dist2;
    logic                w_overflow;
    logic                w_inside;

    always_comb begin
        w_dist2    = '0;
        w_overflow = 1'b0;
        for (int a = 0; a < 3; a++) begin
            w_diff[a] = {pos_q[a][11], pos_q[a]} - {c_centre[a][11], c_centre[a]};
            w_dx[a]   = 26'(signed'(w_diff[a]));
            // |diff| <= 4096, so the square fits in 25 bits and the low 26
            // bits of the product are exact.
            w_sq[a]   = w_dx[a] * w_dx[a];
            w_dist2   = w_dist2 + {2'b00, w_sq[a]};
            w_sum[a]  = {pos_q[a][11], pos_q[a]} + {dir_q[a][11], dir_q[a]};
            // The sum leaves the 12-bit signed range when the two top bits
            // of the 13-bit result disagree.
            w_overflow = w_overflow | (w_sum[a][12] ^ w_sum[a][11]);
        end
        w_inside = (w_dist2 <= C_RADIUS_SQ);
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        step_d      = step_q;
        loc_d       = loc_q;
        hit_d       = hit_q;
        out_valid_d = out_valid_q;
`ifdef RAY_MARCH_STATS_EN
        stats_d     = stats_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dir_d   = dir;
                    pos_d   = c_origin;
                    step_d  = '0;
                    state_d = ST_MARCH;
                end
            end
            ST_MARCH: begin
                if (w_inside || (step_q == C_LAST_STEP) || w_overflow) begin
                    loc_d       = pos_q;
                    hit_d       = w_inside;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef RAY_MARCH_STATS_EN
                    stats_d     = step_q + 1'b1;
`endif
                end else begin
                    for (int a = 0; a < 3; a++) begin
                        pos_d[a] = w_sum[a][11:0];
                    end
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= '0;
            pos_q       <= '0;
            step_q      <= '0;
            loc_q       <= '0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef RAY_MARCH_STATS_EN
            stats_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            step_q      <= step_d;
            loc_q       <= loc_d;
            hit_q       <= hit_d;
            out_valid_q <= out_valid_d;
`ifdef RAY_MARCH_STATS_EN
            stats_q     <= stats_d;
`endif
        end
    end

    assign in_ready              = (state_q == ST_IDLE);
    assign out_valid             = out_valid_q;
    assign intersection_location = loc_q;
    assign is_intersecting       = hit_q;
`ifdef RAY_MARCH_STATS_EN
    assign steps_taken           = stats_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_marcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_marcher
// Purpose  : Directed self-checking bench for ray_marcher. One instance uses
//            the default parameters. A second instance sets ORIGIN_Z = 95 so
//            that its origin lies inside the sphere.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_marcher;

    localparam int STEP_W = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready, is_intersecting;
    logic [2:0][11:0]  dir, intersection_location;
    logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, is_intersecting_b;
    logic [2:0][11:0]  dir_b, intersection_location_b;
`ifdef RAY_MARCH_STATS_EN
    logic [STEP_W-1:0] steps_taken, steps_taken_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    ray_marcher u_dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .dir                   (dir),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .intersection_location (intersection_location),
        .is_intersecting       (is_intersecting)
`ifdef RAY_MARCH_STATS_EN
        ,
        .steps_taken           (steps_taken)
`endif
    );

    ray_marcher #(.ORIGIN_Z(95)) u_dut_in (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid_b),
        .in_ready              (in_ready_b),
        .dir                   (dir_b),
        .out_valid             (out_valid_b),
        .out_ready             (out_ready_b),
        .intersection_location (intersection_location_b),
        .is_intersecting       (is_intersecting_b)
`ifdef RAY_MARCH_STATS_EN
        ,
        .steps_taken           (steps_taken_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a ray to the default instance across one clock edge.
    task automatic accept(input logic [2:0][11:0] d, input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        dir      = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_result(output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dir = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; dir_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_loc",       64'(intersection_location), 64'd0);
        check("rst_hit",       64'(is_intersecting), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ray along +z with step 4: first point within radius 20 of z=100 is 80.
        out_ready = 1'b1;
        accept({12'd4, 12'd0, 12'd0}, "t1");
        wait_result(lat);
        check("t1_latency", 64'(lat), 64'd21);
        check("t1_loc",     64'(intersection_location), 64'({12'd80, 12'd0, 12'd0}));
        check("t1_hit",     64'(is_intersecting), 64'd1);
`ifdef RAY_MARCH_STATS_EN
        check("t1_steps",   64'(steps_taken), 64'd21);
`endif
        @(posedge clk); #1;
        check("t1_release_valid", 64'(out_valid), 64'd0);
        check("t1_release_ready", 64'(in_ready), 64'd1);

        // Ray along +x: never hits, stops after 64 points at x = 63*4.
        accept({12'd0, 12'd0, 12'd4}, "t2");
        wait_result(lat);
        check("t2_latency", 64'(lat), 64'd64);
        check("t2_loc",     64'(intersection_location), 64'({12'd0, 12'd0, 12'd252}));
        check("t2_hit",     64'(is_intersecting), 64'd0);
`ifdef RAY_MARCH_STATS_EN
        check("t2_steps",   64'(steps_taken), 64'd64);
`endif
        @(posedge clk); #1;

        // z step -2047: first advance reaches -2047, second would overflow.
        accept({12'h801, 12'd0, 12'd0}, "t3");
        wait_result(lat);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_loc",     64'(intersection_location), 64'({12'h801, 12'd0, 12'd0}));
        check("t3_hit",     64'(is_intersecting), 64'd0);
`ifdef RAY_MARCH_STATS_EN
        check("t3_steps",   64'(steps_taken), 64'd2);
`endif
        @(posedge clk); #1;

        // Hold the result with out_ready low while in_valid is pulsed.
        out_ready = 1'b0;
        accept({12'd4, 12'd0, 12'd0}, "t4");
        wait_result(lat);
        check("t4_latency", 64'(lat), 64'd21);
        for (int i = 0; i < 5; i++) begin
            dir      = {12'd1, 12'd1, 12'd1};
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_ready", 64'(in_ready), 64'd0);
            check("t4_hold_loc",   64'(intersection_location), 64'({12'd80, 12'd0, 12'd0}));
            check("t4_hold_hit",   64'(is_intersecting), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_release_valid", 64'(out_valid), 64'd0);
        check("t4_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("t4_still_idle", 64'(in_ready), 64'd1);

        // Reset in the middle of a march discards the ray.
        accept({12'd4, 12'd0, 12'd0}, "t5a");
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_loc",   64'(intersection_location), 64'd0);
        check("t5_rst_hit",   64'(is_intersecting), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_no_output", 64'(out_valid), 64'd0);
        accept({12'd5, 12'd0, 12'd0}, "t5b");
        wait_result(lat);
        check("t5_latency", 64'(lat), 64'd17);
        check("t5_loc",     64'(intersection_location), 64'({12'd80, 12'd0, 12'd0}));
        check("t5_hit",     64'(is_intersecting), 64'd1);
`ifdef RAY_MARCH_STATS_EN
        check("t5_steps",   64'(steps_taken), 64'd17);
`endif
        @(posedge clk); #1;

        // Origin z=95 is inside the sphere: zero direction hits at step 0.
        out_ready_b = 1'b1;
        check("t6_in_ready", 64'(in_ready_b), 64'd1);
        dir_b      = '0;
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        check("t6_not_yet", 64'(out_valid_b), 64'd0);
        @(posedge clk); #1;
        check("t6_valid", 64'(out_valid_b), 64'd1);
        check("t6_loc",   64'(intersection_location_b), 64'({12'd95, 12'd0, 12'd0}));
        check("t6_hit",   64'(is_intersecting_b), 64'd1);
`ifdef RAY_MARCH_STATS_EN
        check("t6_steps", 64'(steps_taken_b), 64'd1);
`endif
        @(posedge clk); #1;
        check("t6_release", 64'(out_valid_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
